vga_fetch_buffer: RTL and testbench

Parametrised ping-pong pixel buffer between the AXI read master port and VGA control (VC), all on the single VGA clock. An AR/R burst engine fills two banks alternately from the frame region [base_addr_i, top_addr_i), wrapping to base_addr_i. VC drains the banks one pixel slot per request. Adds a self-test colour-bar mode, underflow and response-error reporting, and proper AXI handshakes.

---
 rtl/vga_fetch_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_vga_fetch_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_buffer.sv
// Ping-pong pixel buffer: an AXI read burst engine fills two banks alternately
// while VGA control drains them one pixel slot per request, with a colour-bar self test.
module vga_fetch_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SLOT_WIDTH = 16,
  parameter int BURST_LEN  = 32,
  parameter int BAR_WIDTH  = 80
) (
  input  logic                  clk_v,
  input  logic                  rst_v,
  input  logic                  enable_i,
  input  logic                  data_req_i,
  input  logic                  self_test_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  output logic [11:0]           data_o,
  output logic                  data_valid_o,
  output logic                  underflow_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [1:0]            arburst_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam int SPB    = DATA_WIDTH / SLOT_WIDTH;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int SLOT_W = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int BAR_W  = $clog2(BAR_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] BYTES = (ADDR_WIDTH + 1)'(BURST_LEN * DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   mem_q [2][BURST_LEN];
  logic [1:0]              full_q, full_d;
  logic                    fill_sel_q, rd_sel_q;
  logic [BEAT_W-1:0]       wr_cnt_q, rd_beat_q;
  logic [SLOT_W-1:0]       rd_slot_q;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [BAR_W-1:0]        bar_cnt_q;
  logic [2:0]              bar_idx_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    arvalid_q, rready_q;
  logic [11:0]             data_q;
  logic                    data_valid_q, underflow_q, resp_err_q;

  logic                    beat_fire, fill_done, drain_req, drain_done;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [11:0]             pixel;

  function automatic logic [11:0] barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'h000;
      3'd1:    return 12'hfff;
      3'd2:    return 12'hf00;
      3'd3:    return 12'h0f0;
      3'd4:    return 12'h00f;
      3'd5:    return 12'hff0;
      3'd6:    return 12'h0ff;
      default: return 12'hf0f;
    endcase
  endfunction

  always_comb begin
    beat_fire  = (state_q == DATA) && rvalid_i && rready_q;
    fill_done  = beat_fire && (rlast_i || (wr_cnt_q == BEAT_W'(BURST_LEN - 1)));
    drain_req  = data_req_i && !self_test_i && full_q[rd_sel_q];
    drain_done = drain_req && (rd_slot_q == SLOT_W'(SPB - 1)) &&
                 (rd_beat_q == BEAT_W'(BURST_LEN - 1));
    // Extra carry bit keeps the top-of-frame compare honest near the address limit
    addr_sum    = {1'b0, next_addr_q} + BYTES;
    next_addr_d = (addr_sum >= {1'b0, top_addr_i}) ? base_addr_i : addr_sum[ADDR_WIDTH-1:0];
    rd_word     = mem_q[rd_sel_q][rd_beat_q];
    pixel       = rd_word[rd_slot_q*SLOT_WIDTH +: 12];
    full_d      = full_q;
    if (fill_done)  full_d[fill_sel_q] = 1'b1;
    if (drain_done) full_d[rd_sel_q]   = 1'b0;
  end

  always_ff @(posedge clk_v) begin
    if (beat_fire) mem_q[fill_sel_q][wr_cnt_q] <= (rresp_i != 2'b00) ? '0 : rdata_i;
  end

  always_ff @(posedge clk_v) begin
    if (rst_v) begin
      state_q      <= IDLE;
      full_q       <= '0;
      fill_sel_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_cnt_q     <= '0;
      rd_beat_q    <= '0;
      rd_slot_q    <= '0;
      next_addr_q  <= base_addr_i;
      bar_cnt_q    <= '0;
      bar_idx_q    <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      full_q <= full_d;

      case (state_q)
        IDLE: begin
          if (enable_i && !full_q[fill_sel_q]) begin
            araddr_q  <= next_addr_q;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (rresp_i != 2'b00) resp_err_q <= 1'b1;
            if (fill_done) begin
              fill_sel_q  <= ~fill_sel_q;
              wr_cnt_q    <= '0;
              rready_q    <= 1'b0;
              next_addr_q <= next_addr_d;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Self test overrides memory reads but leaves the read pointers untouched
      if (data_req_i && self_test_i) begin
        data_q       <= barColour(bar_idx_q);
        data_valid_q <= 1'b1;
        underflow_q  <= 1'b0;
        if (bar_cnt_q == BAR_W'(BAR_WIDTH - 1)) begin
          bar_cnt_q <= '0;
          bar_idx_q <= bar_idx_q + 1'b1;
        end else begin
          bar_cnt_q <= bar_cnt_q + 1'b1;
        end
      end else if (data_req_i) begin
        if (drain_req) begin
          data_q       <= pixel;
          data_valid_q <= 1'b1;
          underflow_q  <= 1'b0;
          if (drain_done) begin
            rd_sel_q  <= ~rd_sel_q;
            rd_beat_q <= '0;
            rd_slot_q <= '0;
          end else if (rd_slot_q == SLOT_W'(SPB - 1)) begin
            rd_slot_q <= '0;
            rd_beat_q <= rd_beat_q + 1'b1;
          end else begin
            rd_slot_q <= rd_slot_q + 1'b1;
          end
        end else begin
          data_valid_q <= 1'b0;
          underflow_q  <= 1'b1;
        end
      end else begin
        data_valid_q <= 1'b0;
        underflow_q  <= 1'b0;
      end

      if (!self_test_i) begin
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign underflow_o  = underflow_q;
  assign resp_err_o   = resp_err_q;
  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign arburst_o    = 2'b01;
  assign arlen_o      = 8'(BURST_LEN - 1);
  assign arsize_o     = 3'($clog2(DATA_WIDTH / 8));

endmodule

// File: tb/tb_vga_fetch_buffer.sv
// Randomized bench for vga_fetch_buffer: an AXI slave plus a pixel-stream reference
// model (completed bursts form a FIFO of pixels, self test is a bar counter).
module tb_vga_fetch_buffer;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int SW    = 16;
  localparam int BL    = 32;
  localparam int BW    = 80;
  localparam int SPB   = DW / SW;
  localparam int PPB   = BL * SPB;
  localparam int BYTES = BL * DW / 8;
  localparam logic [AW-1:0] BASE = 64'h1000;
  localparam logic [AW-1:0] TOP  = 64'h1200;
  localparam int NCYC  = 7000;

  logic          clk_v = 1'b0;
  logic          rst_v;
  logic          enable_i, data_req_i, self_test_i;
  logic [AW-1:0] base_addr_i, top_addr_i;
  logic [11:0]   data_o;
  logic          data_valid_o, underflow_o, resp_err_o;
  logic [AW-1:0] araddr_o;
  logic [1:0]    arburst_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic          arvalid_o, arready_i;
  logic [DW-1:0] rdata_i;
  logic [1:0]    rresp_i;
  logic          rlast_i, rvalid_i, rready_o;

  vga_fetch_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BURST_LEN(BL), .BAR_WIDTH(BW)
  ) dut (
    .clk_v(clk_v), .rst_v(rst_v), .enable_i(enable_i), .data_req_i(data_req_i),
    .self_test_i(self_test_i), .base_addr_i(base_addr_i), .top_addr_i(top_addr_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .underflow_o(underflow_o),
    .resp_err_o(resp_err_o), .araddr_o(araddr_o), .arburst_o(arburst_o),
    .arlen_o(arlen_o), .arsize_o(arsize_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o)
  );

  always #5 clk_v = ~clk_v;

  int vectors = 0;
  int miscompares = 0;

  // Model state: pixels of completed bursts, pixels of the burst in flight
  logic [11:0]   readyPix[$];
  logic [11:0]   curPix[$];
  logic [11:0]   expData = '0;
  bit            expValid = 0, expUnder = 0, errSeen = 0;
  int            stN = 0, arCount = 0, servedCount = 0;
  logic [AW-1:0] expAddr = BASE;

  bit            burstActive = 0;
  int            beatIdx = 0;
  logic [DW-1:0] beatData = '0;
  logic [1:0]    beatResp = '0;

  bit            prevBeatFire = 0, prevArFire = 0, prevArvalid = 0, prevEnable = 0;
  logic [AW-1:0] prevAraddr = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] barColour(input int i);
    case (i)
      0: return 12'h000;  1: return 12'hfff;  2: return 12'hf00;  3: return 12'h0f0;
      4: return 12'h00f;  5: return 12'hff0;  6: return 12'h0ff;  default: return 12'hf0f;
    endcase
  endfunction

  task automatic newBeat();
    beatData = {$urandom, $urandom};
    beatResp = ($urandom_range(0, 15) == 0) ? 2'd2 : 2'd0;
  endtask

  // Drive one cycle of inputs for cycle index c, then predict the served pixel
  task automatic applyStimulus(input int c);
    bit slowR;
    slowR       = (c >= 4300 && c < 5300);
    self_test_i = (c >= 3000 && c < 3700);
    enable_i    = !(c >= 3700 && c < 4000);
    if (self_test_i)     data_req_i = 1'b1;
    else if (c < 40)     data_req_i = ($urandom_range(0, 1) == 1);
    else                 data_req_i = ($urandom_range(0, 7) != 0);
    arready_i = ($urandom_range(0, 1) == 1);
    if (burstActive) begin
      rvalid_i = slowR ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rdata_i  = beatData;
      rresp_i  = beatResp;
      rlast_i  = (beatIdx == BL - 1);
    end else begin
      rvalid_i = 1'b0;
      rdata_i  = '0;
      rresp_i  = '0;
      rlast_i  = 1'b0;
    end

    if (!self_test_i) stN = 0;
    if (data_req_i && self_test_i) begin
      expValid = 1; expUnder = 0;
      expData  = barColour((stN / BW) % 8);
      stN++;
    end else if (data_req_i) begin
      if (readyPix.size() > 0) begin
        expValid = 1; expUnder = 0;
        expData  = readyPix.pop_front();
        servedCount++;
      end else begin
        expValid = 0; expUnder = 1;
      end
    end else begin
      expValid = 0; expUnder = 0;
    end

    prevArFire   = arvalid_o && arready_i;
    prevAraddr   = araddr_o;
    prevArvalid  = arvalid_o;
    prevBeatFire = rvalid_i && rready_o;
    prevEnable   = enable_i;
  endtask

  initial begin
    rst_v = 1'b1;
    enable_i = 0; data_req_i = 0; self_test_i = 0; arready_i = 0;
    rvalid_i = 0; rdata_i = '0; rresp_i = '0; rlast_i = 0;
    base_addr_i = BASE; top_addr_i = TOP;
    repeat (3) @(posedge clk_v);
    #1;
    checkOutput("rst_data", data_o, 12'h000);
    checkOutput("rst_valid", data_valid_o, 0);
    checkOutput("rst_underflow", underflow_o, 0);
    checkOutput("rst_resp_err", resp_err_o, 0);
    checkOutput("rst_arvalid", arvalid_o, 0);
    checkOutput("rst_rready", rready_o, 0);
    checkOutput("arlen", arlen_o, 8'h1f);
    checkOutput("arsize", arsize_o, 3'd3);
    checkOutput("arburst", arburst_o, 2'd1);
    rst_v = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk_v);
      #1;
      checkOutput("data_valid", data_valid_o, expValid);
      checkOutput("underflow", underflow_o, expUnder);
      checkOutput("data", data_o, expData);

      if (prevArFire) begin
        checkOutput("ar_addr", prevAraddr, expAddr);
        checkOutput("ar_bank_free", ((readyPix.size() + PPB - 1) / PPB) <= 1, 1);
        checkOutput("rready_rise", rready_o, 1);
        expAddr = (expAddr + BYTES >= TOP) ? BASE : expAddr + BYTES;
        burstActive = 1;
        beatIdx = 0;
        arCount++;
        newBeat();
      end
      if (prevBeatFire) begin
        if (beatResp != 2'd0) errSeen = 1;
        for (int s = 0; s < SPB; s++)
          curPix.push_back((beatResp != 2'd0) ? 12'h000 : 12'((beatData >> (s * SW)) & 64'hfff));
        beatIdx++;
        if (beatIdx == BL) begin
          while (curPix.size() > 0) readyPix.push_back(curPix.pop_front());
          burstActive = 0;
          checkOutput("rready_fall", rready_o, 0);
        end else begin
          newBeat();
        end
      end
      checkOutput("resp_err", resp_err_o, errSeen);

      if (prevArvalid && !prevArFire) begin
        checkOutput("ar_hold_valid", arvalid_o, 1);
        checkOutput("ar_hold_addr", araddr_o, prevAraddr);
      end
      if (arvalid_o && !prevArvalid) checkOutput("ar_enable", prevEnable, 1);

      applyStimulus(c);
    end

    checkOutput("progress_ar", arCount >= 20, 1);
    checkOutput("progress_pix", servedCount >= 10 * PPB, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
